// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types for the row scan decoder
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SHOW   = 2'd2,
        BLANK  = 2'd3
    } scan_state_t;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } decode_mode_t;

endpackage

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - combinational enable-gated N-to-2^N one-hot decoder
module decoder_onehot #(
    parameter int N = 3
) (
    input  logic               ena_i,
    input  logic [N-1:0]       sel_i,
    output logic [(1<<N)-1:0]  onehot_o
);

    // Exactly one bit set when enabled, all zero otherwise
    always_comb begin
        onehot_o = '0;
        if (ena_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/row_scan_decoder.sv
// rtl/row_scan_decoder.sv - registered one-hot row decoder with auto-scan for LED matrix rows
module row_scan_decoder
    import decoder_pkg::*;
#(
    parameter int N            = 3,
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                mode,
    input  logic [N-1:0]        in,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [(1<<N)-1:0]   out,
    output logic [N-1:0]        row,
    output logic                frame_start,
    output logic                scanning
);

    localparam int ROWS = 1 << N;
    localparam int BW   = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    scan_state_t          state_q, state_d;
    logic [N-1:0]         row_q, row_d;
    logic [ROWS-1:0]      out_q, out_d;
    logic                 fs_q, fs_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]        blank_q, blank_d;

    logic [N-1:0]         sel;
    logic                 sel_en;
    logic [N-1:0]         next_row;
    logic [DWELL_W-1:0]   dwell_eff;

    // A zero dwell would never match the end-of-row compare, so it is lifted to one
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign next_row  = row_q + N'(1);

    // The single decoder sits on the selected next row so out is one-hot by construction
    decoder_onehot #(.N(N)) u_onehot (
        .ena_i    (sel_en),
        .sel_i    (sel),
        .onehot_o (out_d)
    );

    // Next-state, next-row and counter logic in priority order: disable, direct, scan
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        fs_d    = 1'b0;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;
        sel     = row_q;
        sel_en  = 1'b0;

        if (!ena) begin
            state_d = IDLE;
            row_d   = '0;
            sel     = '0;
            cnt_d   = '0;
            blank_d = '0;
        end else if (decode_mode_t'(mode) == MODE_DIRECT) begin
            state_d = DIRECT;
            row_d   = in;
            sel     = in;
            sel_en  = 1'b1;
            cnt_d   = '0;
            blank_d = '0;
        end else begin
            unique case (state_q)
                IDLE, DIRECT: begin
                    state_d = SHOW;
                    row_d   = '0;
                    sel     = '0;
                    sel_en  = 1'b1;
                    fs_d    = 1'b1;
                    dwell_d = dwell_eff;
                    cnt_d   = '0;
                    blank_d = '0;
                end
                SHOW: begin
                    if (cnt_q == dwell_q - DWELL_W'(1)) begin
                        if (BLANK_CYCLES > 0) begin
                            state_d = BLANK;
                            blank_d = '0;
                            cnt_d   = '0;
                        end else begin
                            state_d = SHOW;
                            row_d   = next_row;
                            sel     = next_row;
                            sel_en  = 1'b1;
                            fs_d    = (next_row == '0);
                            dwell_d = dwell_eff;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d  = cnt_q + DWELL_W'(1);
                        sel_en = 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        state_d = SHOW;
                        row_d   = next_row;
                        sel     = next_row;
                        sel_en  = 1'b1;
                        fs_d    = (next_row == '0);
                        dwell_d = dwell_eff;
                        cnt_d   = '0;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = '0;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            out_q   <= '0;
            fs_q    <= 1'b0;
            dwell_q <= '0;
            cnt_q   <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            out_q   <= out_d;
            fs_q    <= fs_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
        end
    end

    assign out         = out_q;
    assign row         = row_q;
    assign frame_start = fs_q;
    assign scanning    = (state_q == SHOW) || (state_q == BLANK);

endmodule
